// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator.
// A clock divider produces a pixel-rate strobe. Horizontal and vertical
// counters step on that strobe. Sync and display-enable are decoded from
// the next-state counter values and then registered, so they change on
// the same edge as the coordinates. A low enable freezes all state.

module vga_sync_gen #(
   parameter int   H_DISPLAY = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_DISPLAY = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic H_POL     = 1'b0,
   parameter logic V_POL     = 1'b0,
   parameter int   DIV       = 2,
   parameter int   CW        = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   output logic          p_tick,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] pixel_y,
   output logic          line_end,
   output logic          frame_end,
   output logic [7:0]    frame_count
);

   // Derived timing constants
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // A one-bit divider counter is kept for DIV=1; it simply stays at zero.
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS        = CW'(H_DISPLAY);
   localparam logic [CW-1:0] V_VIS        = CW'(V_DISPLAY);
   localparam logic [CW-1:0] H_SYNC_START = CW'(H_DISPLAY + H_FRONT);
   localparam logic [CW-1:0] H_SYNC_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [CW-1:0] V_SYNC_START = CW'(V_DISPLAY + V_FRONT);
   localparam logic [CW-1:0] V_SYNC_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   // State registers and their next-state values
   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [CW-1:0] h_cnt_q,   h_cnt_d;
   logic [CW-1:0] v_cnt_q,   v_cnt_d;
   logic          hsync_q,   hsync_d;
   logic          vsync_q,   vsync_d;
   logic          video_q,   video_d;
   logic [7:0]    frame_q,   frame_d;

   // Combinational strobes derived from registered state
   logic tick;
   logic h_end;
   logic v_end;
   logic h_wrap;
   logic f_wrap;

   // The strobes are forced low while reset is held, so that no
   // downstream logic sees a pixel, line or frame boundary during reset.
   assign tick   = reset & enable & (div_cnt_q == DIV_LAST);
   assign h_end  = (h_cnt_q == H_LAST);
   assign v_end  = (v_cnt_q == V_LAST);
   assign h_wrap = tick & h_end;
   assign f_wrap = h_wrap & v_end;

   // Clock divider: count 0..DIV-1 while enabled, hold otherwise
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      div_cnt_d = div_cnt_q;
      if (enable) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
         end else begin
            div_cnt_d = div_cnt_q + DW'(1);
         end
      end
   end

   // Horizontal and vertical counters: step on the pixel strobe, wrap at totals
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (tick) begin
         if (h_end) begin
            h_cnt_d = '0;
            if (v_end) begin
               v_cnt_d = '0;
            end else begin
               v_cnt_d = v_cnt_q + CW'(1);
            end
         end else begin
            h_cnt_d = h_cnt_q + CW'(1);
         end
      end
   end

   // Sync and display-enable decode from the next-state coordinates
   always_comb begin
      hsync_d = ~H_POL;
      vsync_d = ~V_POL;
      video_d = 1'b0;
      if ((h_cnt_d >= H_SYNC_START) && (h_cnt_d <= H_SYNC_END)) begin
         hsync_d = H_POL;
      end
      if ((v_cnt_d >= V_SYNC_START) && (v_cnt_d <= V_SYNC_END)) begin
         vsync_d = V_POL;
      end
      if ((h_cnt_d < H_VIS) && (v_cnt_d < V_VIS)) begin
         video_d = 1'b1;
      end
   end

   // Completed-frame counter: bump on the frame boundary, wrap naturally at 8 bits
   always_comb begin
      frame_d = frame_q;
      if (f_wrap) begin
         frame_d = frame_q + 8'd1;
      end
   end

   // State update: synchronous active-low reset, freeze when enable is low
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (!reset) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         hsync_q   <= ~H_POL;
         vsync_q   <= ~V_POL;
         video_q   <= 1'b0;
         frame_q   <= '0;
      end else if (enable) begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         video_q   <= video_d;
         frame_q   <= frame_d;
      end
   end

   // Output mapping
   assign p_tick      = tick;
   assign line_end    = h_wrap;
   assign frame_end   = f_wrap;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_q;
   assign pixel_x     = h_cnt_q;
   assign pixel_y     = v_cnt_q;
   assign frame_count = frame_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised VGA timing generator that replaces the fixed 640x480 synchroniser. Sits between the system clock and the pixel/character generators. It produces horizontal and vertical sync, the display-enable window, pixel coordinates, a pixel-rate strobe, and line/frame boundary strobes. Resolution, porches, sync widths, sync polarity and the clock-to-pixel divide ratio are all parameters, and a run/freeze enable is added.

## Interface
Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- DIV, 2, clk cycles per pixel; must be ≥1
- CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  run when high; freeze all state when low
- p_tick  out  1  pixel strobe
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- video_on  out  1  high inside the visible window, registered
- pixel_x  out  CW  current column
- pixel_y  out  CW  current row
- line_end  out  1  strobe on the last pixel of every line
- frame_end  out  1  strobe on the last pixel of every frame
- frame_count  out  8  completed-frame counter, wraps 255→0

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK. V_TOTAL is defined the same way from the V parameters.
- Region order along each axis: display, front porch, sync, back porch.
- Divider counter div_cnt runs from 0 to DIV-1.
  - p_tick = enable & (div_cnt == DIV-1).
  - With DIV=1, p_tick equals enable.
- h_count advances on each clock edge where p_tick=1, wrapping from H_TOTAL-1 to 0.
- v_count advances on a p_tick edge where h_count = H_TOTAL-1, wrapping from V_TOTAL-1 to 0.
- pixel_x = h_count and pixel_y = v_count.
- hsync, vsync and video_on are registered. Each is decoded from the next-state counter values, so it changes on the same edge as pixel_x/pixel_y, with zero lag relative to the coordinates.
- hsync is active when H_DISPLAY+H_FRONT ≤ h ≤ H_DISPLAY+H_FRONT+H_SYNC-1.
- vsync is active over the equivalent range of lines.
- video_on = (h < H_DISPLAY) & (v < V_DISPLAY).
- line_end = p_tick & (h_count == H_TOTAL-1). It is combinational from registers.
- frame_end = line_end & (v_count == V_TOTAL-1).
- frame_count increments on the edge where frame_end=1.
- enable low: div_cnt, counters, sync/video registers and frame_count all hold. p_tick, line_end and frame_end read 0.

## Timing
- Reset is sampled only at a clock edge with reset=0. That edge loads:
  - div_cnt = 0, pixel_x = 0, pixel_y = 0, frame_count = 0
  - video_on = 0
  - hsync = ~H_POL, vsync = ~V_POL (inactive levels)
- While reset is held low: p_tick, line_end and frame_end are 0.
- The first rising edge with reset=1 sets video_on=1, since position (0,0) is visible. Counters advance on the first p_tick after that.
- With DIV>1, each pixel lasts exactly DIV clk cycles. p_tick is high in the last cycle of each pixel.
- Line period is H_TOTAL·DIV clk cycles. Frame period is H_TOTAL·V_TOTAL·DIV clk cycles.
- Reset asserted mid-frame aborts immediately to the reset state. No partial sync pulse is extended.
- The h-wrap and v-wrap happen on the same edge at frame end, giving (H_TOTAL-1, V_TOTAL-1) → (0, 0).
- Dropping enable on a p_tick cycle suppresses that advance.

## Test plan
- Defaults, reset released, free-run 840000 clk cycles:
  - frame_end pulses exactly once, at pixel (799, 524).
  - frame_count reaches 1.
  - p_tick toggles every cycle.
- Defaults, one line:
  - hsync low exactly for pixel_x 656..751 (192 clk cycles).
  - video_on high for pixel_x 0..639 on rows 0..479 and low on row 480.
  - vsync low exactly for pixel_y 490..491.
- Small config, DIV=1, H 8/2/2/2, V 4/1/1/1, H_POL=V_POL=1:
  - H_TOTAL=14, V_TOTAL=7.
  - hsync high for x 10..11 and vsync high for y 5.
  - frame_end every 98 cycles.
  - frame_count wraps 255→0 after 256 frames.
- DIV=3:
  - pixel_x holds each value for exactly 3 cycles.
  - p_tick is high on the third cycle of each pixel.
  - line_end coincides with the p_tick at x = H_TOTAL-1.
- enable dropped for 50 cycles at pixel (700, 100):
  - All outputs freeze and strobes read 0.
  - On re-enable, counting resumes from (700, 100) without skipping.
- Reset (0) asserted for 1 cycle at pixel (660, 491), inside both sync pulses:
  - The next cycle shows pixel (0, 0), syncs inactive, video_on=0, frame_count=0.
  - The cycle after reset release shows video_on=1.
